// File: rtl/store_buffer.sv
// store_buffer: posted-write FIFO in front of the data memory, owning the DM address/op mux.
// Define STORE_BUF_FWD_EN to forward loads fully covered by the youngest matching store.
module store_buffer #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned PTR_W = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        st_valid,
  input  logic [31:0] st_addr,
  input  logic [31:0] st_data,
  input  logic [3:0]  st_op,
  output logic        st_ready,
  input  logic        ld_valid,
  input  logic [31:0] ld_addr,
  input  logic [3:0]  ld_op,
  output logic        ld_stall,
  output logic        ld_fwd_valid,
  output logic [31:0] ld_fwd_data,
  output logic [31:0] dm_addr,
  output logic [31:0] dm_wdata,
  output logic [3:0]  dm_op,
  output logic        empty
);
  localparam int unsigned CNT_W = PTR_W + 1;
  // Width codes carried in op[3:1], shared with the data memory.
  localparam logic [2:0] WC_BYTE  = 3'd1;
  localparam logic [2:0] WC_BYTEU = 3'd2;
  localparam logic [2:0] WC_HALF  = 3'd3;
  localparam logic [2:0] WC_HALFU = 3'd4;

  function automatic logic [3:0] lane_mask(input logic [2:0] wc, input logic [1:0] off);
    case (wc)
      WC_HALF, WC_HALFU: lane_mask = 4'b0011 << {off[1], 1'b0};
      WC_BYTE, WC_BYTEU: lane_mask = 4'b0001 << off;
      default:           lane_mask = 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] bit_mask(input logic [3:0] m);
    bit_mask = {{8{m[3]}}, {8{m[2]}}, {8{m[1]}}, {8{m[0]}}};
  endfunction

  logic [DEPTH-1:0] valid_q;
  logic [29:0]      word_q [DEPTH];
  logic [1:0]       off_q  [DEPTH];
  logic [3:0]       op_q   [DEPTH];
  logic [3:0]       mask_q [DEPTH];
  logic [31:0]      data_q [DEPTH];
  logic [PTR_W-1:0] head_q, tail_q;
  logic [CNT_W-1:0] count_q;

  logic             full, push, drain, load_own, any_match;
  logic [DEPTH-1:0] match;
  logic [3:0]       ld_mask, st_mask;

  assign full     = (count_q == CNT_W'(DEPTH));
  assign empty    = (count_q == '0);
  assign st_ready = !full;
  assign push     = st_valid && st_ready;
  assign ld_mask  = lane_mask(ld_op[3:1], ld_addr[1:0]);
  assign st_mask  = lane_mask(st_op[3:1], st_addr[1:0]);

  always_comb begin
    match = '0;
    for (int i = 0; i < DEPTH; i++)
      match[i] = valid_q[i] && (word_q[i] == ld_addr[31:2]) && ((mask_q[i] & ld_mask) != 4'b0000);
  end

`ifdef STORE_BUF_FWD_EN
  logic [PTR_W-1:0] age_idx, y_idx;
  logic             cover;
  logic [31:0]      y_lane;

  // Walk oldest to youngest so the last hit is the youngest matching store.
  always_comb begin
    any_match = 1'b0;
    y_idx     = '0;
    age_idx   = '0;
    for (int k = 0; k < DEPTH; k++) begin
      age_idx = head_q + PTR_W'(k);
      if (match[age_idx]) begin
        any_match = 1'b1;
        y_idx     = age_idx;
      end
    end
  end

  assign cover        = ((mask_q[y_idx] & ld_mask) == ld_mask);
  assign ld_stall     = ld_valid && any_match && !cover;
  assign ld_fwd_valid = ld_valid && any_match && cover;
  assign y_lane       = data_q[y_idx] >> {ld_addr[1:0], 3'b000};

  always_comb begin
    ld_fwd_data = 32'h0;
    if (ld_fwd_valid) begin
      case (ld_op[3:1])
        WC_BYTE:  ld_fwd_data = {{24{y_lane[7]}}, y_lane[7:0]};
        WC_BYTEU: ld_fwd_data = {24'h0, y_lane[7:0]};
        WC_HALF:  ld_fwd_data = {{16{y_lane[15]}}, y_lane[15:0]};
        WC_HALFU: ld_fwd_data = {16'h0, y_lane[15:0]};
        default:  ld_fwd_data = y_lane;
      endcase
    end
  end
`else
  assign any_match    = |match;
  assign ld_stall     = ld_valid && any_match;
  assign ld_fwd_valid = 1'b0;
  assign ld_fwd_data  = 32'h0;
`endif

  // DM port: an unstalled, unforwarded load wins; otherwise drain the head entry.
  assign load_own = ld_valid && !ld_stall && !ld_fwd_valid;
  assign drain    = !reset && !load_own && !empty;

  always_comb begin
    dm_addr  = 32'h0;
    dm_op    = 4'b0000;
    dm_wdata = 32'h0;
    if (load_own) begin
      dm_addr = ld_addr;
      dm_op   = ld_op;
    end else if (drain) begin
      dm_addr  = {word_q[head_q], off_q[head_q]};
      dm_op    = op_q[head_q];
      dm_wdata = data_q[head_q] >> {off_q[head_q], 3'b000};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      valid_q <= '0;
    end else begin
      if (push) begin
        tail_q          <= tail_q + PTR_W'(1);
        valid_q[tail_q] <= 1'b1;
      end
      if (drain) begin
        head_q          <= head_q + PTR_W'(1);
        valid_q[head_q] <= 1'b0;
      end
      case ({push, drain})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Payload needs no reset; valid_q alone decides occupancy. Buffered entries always drain as writes.
  always_ff @(posedge clk) begin
    if (push) begin
      word_q[tail_q] <= st_addr[31:2];
      off_q[tail_q]  <= st_addr[1:0];
      op_q[tail_q]   <= {st_op[3:1], st_op[0] | 1'b1};
      mask_q[tail_q] <= st_mask;
      data_q[tail_q] <= (st_data << {st_addr[1:0], 3'b000}) & bit_mask(st_mask);
    end
  end
endmodule

// File: tb/tb_store_buffer.sv
// tb_store_buffer: directed and random stimulus against a byte-range queue model of the store buffer.
// Forwarding checks are compiled in when STORE_BUF_FWD_EN is defined.
module tb_store_buffer;
  localparam logic [2:0] WC_BYTE = 3'd1, WC_BYTEU = 3'd2, WC_HALF = 3'd3, WC_HALFU = 3'd4, WC_WORD = 3'd5;
  localparam logic [3:0] OP_SW = {WC_WORD, 1'b1}, OP_SH = {WC_HALF, 1'b1}, OP_SB = {WC_BYTE, 1'b1};
  localparam logic [3:0] OP_LW = {WC_WORD, 1'b0}, OP_LB = {WC_BYTE, 1'b0};

  logic        clk = 1'b0;
  logic        reset, st_valid, ld_valid;
  logic [31:0] st_addr, st_data, ld_addr;
  logic [3:0]  st_op, ld_op;
  logic        st_ready, ld_stall, ld_fwd_valid, empty;
  logic [31:0] ld_fwd_data, dm_addr, dm_wdata;
  logic [3:0]  dm_op;

  always #5 clk = ~clk;

  store_buffer dut (
    .clk(clk), .reset(reset),
    .st_valid(st_valid), .st_addr(st_addr), .st_data(st_data), .st_op(st_op), .st_ready(st_ready),
    .ld_valid(ld_valid), .ld_addr(ld_addr), .ld_op(ld_op), .ld_stall(ld_stall),
    .ld_fwd_valid(ld_fwd_valid), .ld_fwd_data(ld_fwd_data),
    .dm_addr(dm_addr), .dm_wdata(dm_wdata), .dm_op(dm_op), .empty(empty)
  );

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    logic [2:0]  wc;
  } st_t;

  st_t q[$];
  int  ncmp = 0;
  int  nerr = 0;

  logic        e_stall, e_fwdv, e_ready, e_empty, e_drain;
  logic [31:0] e_fwdd, e_addr, e_wdata;
  logic [3:0]  e_op;

  function automatic int unsigned sz(input logic [2:0] wc);
    case (wc)
      WC_BYTE, WC_BYTEU: return 1;
      WC_HALF, WC_HALFU: return 2;
      default:           return 4;
    endcase
  endfunction

  function automatic logic [31:0] extend(input logic [31:0] v, input logic [2:0] wc);
    case (wc)
      WC_BYTE:  return {{24{v[7]}}, v[7:0]};
      WC_BYTEU: return {24'h0, v[7:0]};
      WC_HALF:  return {{16{v[15]}}, v[15:0]};
      WC_HALFU: return {16'h0, v[15:0]};
      default:  return v;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Expected outputs from byte-address ranges of the queued stores and the current inputs.
  task automatic check();
    int          y;
    int unsigned lsz, ysz;
    logic [31:0] val;
    y = -1;
    lsz = sz(ld_op[3:1]);
    for (int i = 0; i < q.size(); i++)
      if (ld_valid && q[i].addr < ld_addr + lsz && ld_addr < q[i].addr + sz(q[i].wc)) y = i;
    e_stall = 1'b0; e_fwdv = 1'b0; e_fwdd = 32'h0;
    if (y >= 0) begin
`ifdef STORE_BUF_FWD_EN
      ysz = sz(q[y].wc);
      if (q[y].addr <= ld_addr && ld_addr + lsz <= q[y].addr + ysz) begin
        e_fwdv = 1'b1;
        val = 32'h0;
        for (int b = 0; b < int'(lsz); b++)
          val |= ((q[y].data >> (8 * (ld_addr + 32'(b) - q[y].addr))) & 32'hFF) << (8 * b);
        e_fwdd = extend(val, ld_op[3:1]);
      end else e_stall = 1'b1;
`else
      ysz = 0;
      val = 32'h0;
      e_stall = 1'b1;
`endif
    end
    e_ready = (q.size() < 4);
    e_empty = (q.size() == 0);
    e_op = 4'h0; e_addr = 32'h0; e_wdata = 32'h0; e_drain = 1'b0;
    if (ld_valid && !e_stall && !e_fwdv) begin
      e_addr = ld_addr;
      e_op   = ld_op;
    end else if (!reset && q.size() > 0) begin
      e_drain = 1'b1;
      e_addr  = q[0].addr;
      e_op    = {q[0].wc, 1'b1};
      e_wdata = q[0].data;
    end
    chk("st_ready", 32'(st_ready), 32'(e_ready));
    chk("empty", 32'(empty), 32'(e_empty));
    chk("ld_stall", 32'(ld_stall), 32'(e_stall));
    chk("ld_fwd_valid", 32'(ld_fwd_valid), 32'(e_fwdv));
    chk("ld_fwd_data", ld_fwd_data, e_fwdd);
    chk("dm_addr", dm_addr, e_addr);
    chk("dm_op", 32'(dm_op), 32'(e_op));
    chk("dm_wdata", dm_wdata, e_wdata);
  endtask

  task automatic step(input bit rst, input bit sv, input logic [31:0] sa, input logic [31:0] sd,
                      input logic [3:0] so, input bit lv, input logic [31:0] la, input logic [3:0] lo);
    reset = rst; st_valid = sv; st_addr = sa; st_data = sd; st_op = so;
    ld_valid = lv; ld_addr = la; ld_op = lo;
    #1;
    check();
  endtask

  // Advance the model with the inputs of the current cycle, then move past the clock edge.
  task automatic tick();
    st_t         e;
    int unsigned s;
    if (reset) q.delete();
    else begin
      if (e_drain) void'(q.pop_front());
      if (st_valid && e_ready) begin
        s = sz(st_op[3:1]);
        e.wc   = st_op[3:1];
        e.addr = st_addr;
        e.data = (s == 4) ? st_data : (st_data & ((32'(1) << (8 * s)) - 32'(1)));
        q.push_back(e);
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 32'h0, 4'h0);
    tick();
  endtask

  logic [2:0]  wc;
  logic [31:0] a;
  int unsigned r;

  initial begin
    reset = 1'b1; st_valid = 1'b0; st_addr = 32'h0; st_data = 32'h0; st_op = 4'h0;
    ld_valid = 1'b0; ld_addr = 32'h0; ld_op = 4'h0;
    @(posedge clk);
    #1;
    step(1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 32'h0, 4'h0);
    chk("reset_empty", 32'(empty), 32'd1);
    chk("reset_ready", 32'(st_ready), 32'd1);
    chk("reset_dm_op", 32'(dm_op), 32'd0);
    tick();

    // Five sw with a far load holding the DM port so the buffer fills.
    for (int i = 0; i < 4; i++) begin
      step(1'b0, 1'b1, 32'(4 * i), 32'h1000 + 32'(i), OP_SW, 1'b1, 32'h100, OP_LW);
      tick();
    end
    step(1'b0, 1'b1, 32'h10, 32'h1004, OP_SW, 1'b1, 32'h100, OP_LW);
    chk("full_ready", 32'(st_ready), 32'd0);
    tick();
    step(1'b0, 1'b1, 32'h10, 32'h1004, OP_SW, 1'b0, 32'h0, 4'h0);
    chk("full_drain_ready", 32'(st_ready), 32'd0);
    chk("full_drain_addr", dm_addr, 32'h0);
    tick();
    step(1'b0, 1'b1, 32'h10, 32'h1004, OP_SW, 1'b0, 32'h0, 4'h0);
    chk("fifth_ready", 32'(st_ready), 32'd1);
    chk("second_drain_addr", dm_addr, 32'h4);
    tick();
    for (int i = 0; i < 5; i++) idle();
    chk("drained_empty", 32'(empty), 32'd1);

    // sb then overlapping lw: one stall cycle while the byte drains.
    step(1'b0, 1'b1, 32'h3, 32'h000000AB, OP_SB, 1'b0, 32'h0, 4'h0);
    tick();
    step(1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b1, 32'h0, OP_LW);
    chk("sb_lw_stall", 32'(ld_stall), 32'd1);
    chk("sb_lw_dm_op", 32'(dm_op), 32'(OP_SB));
    chk("sb_lw_dm_addr", dm_addr, 32'h3);
    chk("sb_lw_wdata", dm_wdata, 32'hAB);
    tick();
    step(1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b1, 32'h0, OP_LW);
    chk("sb_lw_release", 32'(ld_stall), 32'd0);
    chk("sb_lw_load_op", 32'(dm_op), 32'(OP_LW));
    tick();

    // sh then non-overlapping lw: load first, store after.
    step(1'b0, 1'b1, 32'h2, 32'hDEAD1234, OP_SH, 1'b0, 32'h0, 4'h0);
    tick();
    step(1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b1, 32'h4, OP_LW);
    chk("sh_lw_nostall", 32'(ld_stall), 32'd0);
    chk("sh_lw_dm_addr", dm_addr, 32'h4);
    tick();
    step(1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 32'h0, 4'h0);
    chk("sh_drain_wdata", dm_wdata, 32'h1234);
    chk("sh_drain_op", 32'(dm_op), 32'(OP_SH));
    tick();

`ifdef STORE_BUF_FWD_EN
    step(1'b0, 1'b1, 32'h8, 32'h80FF7F01, OP_SW, 1'b0, 32'h0, 4'h0);
    tick();
    step(1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b1, 32'h9, OP_LB);
    chk("fwd_valid", 32'(ld_fwd_valid), 32'd1);
    chk("fwd_data", ld_fwd_data, 32'h0000007F);
    chk("fwd_nostall", 32'(ld_stall), 32'd0);
    tick();
    step(1'b0, 1'b1, 32'h8, 32'h55, OP_SB, 1'b0, 32'h0, 4'h0);
    tick();
    step(1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b1, 32'h8, OP_LW);
    chk("partial_stall", 32'(ld_stall), 32'd1);
    chk("partial_nofwd", 32'(ld_fwd_valid), 32'd0);
    tick();
    idle();
`endif

    // Three entries buffered, then reset: nothing is written afterwards.
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b1, 32'h20 + 32'(4 * i), 32'hC0DE0000 + 32'(i), OP_SW, 1'b1, 32'h100, OP_LW);
      tick();
    end
    step(1'b1, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 32'h0, 4'h0);
    chk("reset_cycle_nowrite", 32'(dm_op[0]), 32'd0);
    tick();
    step(1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 32'h0, 4'h0);
    chk("post_reset_empty", 32'(empty), 32'd1);
    chk("post_reset_nowrite", 32'(dm_op), 32'd0);
    tick();

    // Random traffic; a store paired with a far load lets occupancy build up.
    for (int n = 0; n < 600; n++) begin
      r = $urandom_range(0, 9);
      case ($urandom_range(0, 4))
        0:       wc = WC_BYTE;
        1:       wc = WC_BYTEU;
        2:       wc = WC_HALF;
        3:       wc = WC_HALFU;
        default: wc = WC_WORD;
      endcase
      a = 32'($urandom_range(0, 15)) & ~32'(sz(wc) - 1);
      if ($urandom_range(0, 59) == 0)
        step(1'b1, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 32'h0, 4'h0);
      else if (r < 4)
        step(1'b0, 1'b1, a, $urandom, {(wc == WC_BYTEU) ? WC_BYTE : (wc == WC_HALFU) ? WC_HALF : wc, 1'b1},
             1'b0, 32'h0, 4'h0);
      else if (r < 7)
        step(1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b1, a, {wc, 1'b0});
      else if (r < 9)
        step(1'b0, 1'b1, a, $urandom, {(wc == WC_BYTEU) ? WC_BYTE : (wc == WC_HALFU) ? WC_HALF : wc, 1'b1},
             1'b1, 32'h100 + a, OP_LW);
      else
        step(1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 32'h0, 4'h0);
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end
endmodule
